// File: rtl/vend_disp_pkg.sv
// Shared types, glyphs and helpers for the vending machine front-panel display.
//   SEG_BLANK / SEG_DASH : glyph constants, bit order {A,B,C,D,E,F,G}
//   seg7_dec             : BCD digit -> glyph, non-decimal codes show a dash
//   pow10                : 10**n, used to size the overflow threshold
//   conv_state_t         : binary-to-BCD converter states
package vend_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } conv_state_t;

    // Panel glyph set; 7 is drawn with the F segment hook.
    function automatic logic [6:0] seg7_dec(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1111110;
            4'd1:    g = 7'b0110000;
            4'd2:    g = 7'b1101101;
            4'd3:    g = 7'b1111001;
            4'd4:    g = 7'b0110011;
            4'd5:    g = 7'b1011011;
            4'd6:    g = 7'b1011111;
            4'd7:    g = 7'b1110010;
            4'd8:    g = 7'b1111111;
            4'd9:    g = 7'b1111011;
            default: g = SEG_DASH;
        endcase
        return g;
    endfunction

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/seg7_scan_display_bin2bcd.sv
// Sequential binary-to-BCD converter (double-dabble, one shift per cycle).
//   FPGA_CLK, FPGA_RSTB : clock, async active-low reset
//   value_in/value_load : value and 1-cycle capture strobe
//   digits              : committed BCD digits, digit 0 in bits [3:0]
//   busy                : conversion running or pending
//   overflow            : committed value did not fit in NUM_DIGITS digits
module bin2bcd_seq
    import vend_disp_pkg::*;
#(
    parameter int unsigned VAL_W      = 20,
    parameter int unsigned NUM_DIGITS = 6
) (
    input  logic                    FPGA_CLK,
    input  logic                    FPGA_RSTB,
    input  logic [VAL_W-1:0]        value_in,
    input  logic                    value_load,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    busy,
    output logic                    overflow
);

    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned SCR_W = BCD_W + VAL_W;
    localparam int unsigned CNT_W = (VAL_W < 2) ? 1 : $clog2(VAL_W + 1);
    localparam longint unsigned OVF_LIMIT = pow10(NUM_DIGITS);

    conv_state_t       state;
    logic [SCR_W-1:0]  scratch;
    logic [CNT_W-1:0]  shift_cnt;
    logic              ovf_cap;
    logic              pend;
    logic [VAL_W-1:0]  pend_val;

    logic [SCR_W-1:0]  scratch_adj_c;
    logic [SCR_W-1:0]  scratch_shift_c;
    logic [VAL_W-1:0]  start_val_c;
    logic              start_ovf_c;

    // Add-3 correction on every BCD nibble, then one left shift.
    always_comb begin
        scratch_adj_c = scratch;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (scratch[VAL_W + 4*i +: 4] >= 4'd5) begin
                scratch_adj_c[VAL_W + 4*i +: 4] = scratch[VAL_W + 4*i +: 4] + 4'd3;
            end
        end
        scratch_shift_c = {scratch_adj_c[SCR_W-2:0], 1'b0};
    end

    // A restart from COMMIT takes a same-cycle load over the pending value.
    always_comb begin
        start_val_c = value_in;
        if (state == COMMIT && !value_load) begin
            start_val_c = pend_val;
        end
        start_ovf_c = 64'(start_val_c) >= OVF_LIMIT;
    end

    // Converter FSM: IDLE -> CONV (VAL_W shifts) -> COMMIT -> IDLE or CONV.
    always_ff @(posedge FPGA_CLK or negedge FPGA_RSTB) begin
        if (!FPGA_RSTB) begin
            state     <= IDLE;
            scratch   <= '0;
            shift_cnt <= '0;
            ovf_cap   <= 1'b0;
            pend      <= 1'b0;
            pend_val  <= '0;
            digits    <= '0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (value_load) begin
                        scratch   <= {BCD_W'(0), start_val_c};
                        shift_cnt <= '0;
                        ovf_cap   <= start_ovf_c;
                        busy      <= 1'b1;
                        state     <= CONV;
                    end
                end
                CONV: begin
                    scratch   <= scratch_shift_c;
                    shift_cnt <= shift_cnt + CNT_W'(1);
                    if (shift_cnt == CNT_W'(VAL_W - 1)) begin
                        state <= COMMIT;
                    end
                    if (value_load) begin
                        pend_val <= value_in;
                        pend     <= 1'b1;
                    end
                end
                COMMIT: begin
                    // A superseded result is dropped rather than shown briefly.
                    if (value_load || pend) begin
                        scratch   <= {BCD_W'(0), start_val_c};
                        shift_cnt <= '0;
                        ovf_cap   <= start_ovf_c;
                        pend      <= 1'b0;
                        state     <= CONV;
                    end else begin
                        digits   <= scratch[SCR_W-1 -: BCD_W];
                        overflow <= ovf_cap;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed N-digit 7-segment driver with sequential decimal conversion.
//   FPGA_CLK, FPGA_RSTB : clock, async active-low reset
//   value_in/value_load : binary value and capture strobe
//   blank_lz            : blank leading zeros (digit 0 always lit)
//   dp_mask             : decimal point per digit, bit0 = rightmost
//   DIGIT               : active-high digit enables, one-hot or zero
//   SEG, SEG_DP         : segments {A..G} and decimal point of the active digit
//   busy, overflow      : converter status
module seg7_scan_display
    import vend_disp_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned VAL_W      = 20,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned GHOST_CYC  = 64,
    parameter bit          SEG_INV    = 1'b0
) (
    input  logic                  FPGA_CLK,
    input  logic                  FPGA_RSTB,
    input  logic [VAL_W-1:0]      value_in,
    input  logic                  value_load,
    input  logic                  blank_lz,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic [NUM_DIGITS-1:0] DIGIT,
    output logic [6:0]            SEG,
    output logic                  SEG_DP,
    output logic                  busy,
    output logic                  overflow
);

    localparam int unsigned SLOT_W = (SCAN_DIV < 2) ? 1 : $clog2(SCAN_DIV);
    localparam int unsigned IDX_W  = (NUM_DIGITS < 2) ? 1 : $clog2(NUM_DIGITS);

    logic [4*NUM_DIGITS-1:0] digits;
    logic [SLOT_W-1:0]       slot_cnt;
    logic [IDX_W-1:0]        scan_idx;

    logic [SLOT_W-1:0]       slot_nxt_c;
    logic [IDX_W-1:0]        idx_nxt_c;
    logic [NUM_DIGITS-1:0]   lit_c;
    logic [3:0]              sel_nib_c;
    logic                    sel_lit_c;
    logic                    sel_dp_c;
    logic [6:0]              glyph_c;

    bin2bcd_seq #(
        .VAL_W      (VAL_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .FPGA_CLK   (FPGA_CLK),
        .FPGA_RSTB  (FPGA_RSTB),
        .value_in   (value_in),
        .value_load (value_load),
        .digits     (digits),
        .busy       (busy),
        .overflow   (overflow)
    );

    // Next slot counter / scan index.
    always_comb begin
        slot_nxt_c = slot_cnt + SLOT_W'(1);
        idx_nxt_c  = scan_idx;
        if (slot_cnt == SLOT_W'(SCAN_DIV - 1)) begin
            slot_nxt_c = '0;
            if (scan_idx == IDX_W'(NUM_DIGITS - 1)) begin
                idx_nxt_c = '0;
            end else begin
                idx_nxt_c = scan_idx + IDX_W'(1);
            end
        end
    end

    // A digit is lit once any digit at or above it is non-zero.
    always_comb begin
        logic nz;
        nz    = 1'b0;
        lit_c = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            nz       = nz | (digits[4*i +: 4] != 4'd0);
            lit_c[i] = nz | (i == 0) | ~blank_lz;
        end
    end

    // Glyph for the digit whose slot is about to start.
    always_comb begin
        sel_nib_c = 4'd0;
        sel_lit_c = 1'b0;
        sel_dp_c  = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx_nxt_c == IDX_W'(i)) begin
                sel_nib_c = digits[4*i +: 4];
                sel_lit_c = lit_c[i];
                sel_dp_c  = dp_mask[i];
            end
        end
        if (overflow) begin
            glyph_c = SEG_DASH;
        end else if (!sel_lit_c) begin
            glyph_c = SEG_BLANK;
        end else begin
            glyph_c = seg7_dec(sel_nib_c);
        end
    end

    // Scan counters and output registers; segments only load at slot start.
    always_ff @(posedge FPGA_CLK or negedge FPGA_RSTB) begin
        if (!FPGA_RSTB) begin
            slot_cnt <= '0;
            scan_idx <= '0;
            DIGIT    <= '0;
            SEG      <= {7{SEG_INV}};
            SEG_DP   <= SEG_INV;
        end else begin
            slot_cnt <= slot_nxt_c;
            scan_idx <= idx_nxt_c;
            if (32'(slot_nxt_c) < GHOST_CYC) begin
                DIGIT <= '0;
            end else begin
                DIGIT <= NUM_DIGITS'(1) << idx_nxt_c;
            end
            if (slot_nxt_c == '0) begin
                SEG    <= glyph_c ^ {7{SEG_INV}};
                SEG_DP <= sel_dp_c ^ SEG_INV;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display (4 digits, 14-bit value, 8-cycle slots).
module tb_seg7_scan_display;

    logic        FPGA_CLK;
    logic        FPGA_RSTB;
    logic [13:0] value_in;
    logic        value_load;
    logic        blank_lz;
    logic [3:0]  dp_mask;
    logic [3:0]  DIGIT;
    logic [6:0]  SEG;
    logic        SEG_DP;
    logic        busy;
    logic        overflow;

    int n_chk;
    int n_bad;
    logic [6:0] fr_seg [4];
    logic       fr_dp  [4];

    seg7_scan_display #(
        .NUM_DIGITS (4),
        .VAL_W      (14),
        .SCAN_DIV   (8),
        .GHOST_CYC  (1),
        .SEG_INV    (1'b0)
    ) dut (
        .FPGA_CLK   (FPGA_CLK),
        .FPGA_RSTB  (FPGA_RSTB),
        .value_in   (value_in),
        .value_load (value_load),
        .blank_lz   (blank_lz),
        .dp_mask    (dp_mask),
        .DIGIT      (DIGIT),
        .SEG        (SEG),
        .SEG_DP     (SEG_DP),
        .busy       (busy),
        .overflow   (overflow)
    );

    initial FPGA_CLK = 1'b0;
    always #5 FPGA_CLK = ~FPGA_CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Strobe value_load for one edge; returns at the negedge after capture.
    task automatic pulse_load(input logic [13:0] v);
        @(negedge FPGA_CLK);
        value_in   = v;
        value_load = 1'b1;
        @(negedge FPGA_CLK);
        value_load = 1'b0;
    endtask

    // Count busy-high cycles from the capture edge; optionally reload at count inj_at.
    task automatic measure_busy(input int inj_at, input logic [13:0] inj_val, output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (n == inj_at) begin
                value_in   = inj_val;
                value_load = 1'b1;
            end
            @(negedge FPGA_CLK);
            value_load = 1'b0;
        end
    endtask

    task automatic grab_frame();
        for (int i = 0; i < 4; i++) begin
            int n;
            logic [3:0] want;
            want = 4'b0001 << i;
            n = 0;
            while (DIGIT != want && n < 100) begin
                @(negedge FPGA_CLK);
                n++;
            end
            check_val($sformatf("scan_found%0d", i), 32'(n < 100), 32'd1);
            fr_seg[i] = SEG;
            fr_dp[i]  = SEG_DP;
        end
    endtask

    task automatic check_frame(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                               input logic [6:0] e1, input logic [6:0] e0, input logic [3:0] edp);
        logic [6:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        repeat (40) @(negedge FPGA_CLK);
        grab_frame();
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("%s_seg%0d", tag, i), 32'(fr_seg[i]), 32'(e[i]));
            check_val($sformatf("%s_dp%0d", tag, i), 32'(fr_dp[i]), 32'(edp[i]));
        end
    endtask

    localparam logic [6:0] G0 = 7'b1111110;
    localparam logic [6:0] G1 = 7'b0110000;
    localparam logic [6:0] G2 = 7'b1101101;
    localparam logic [6:0] G3 = 7'b1111001;
    localparam logic [6:0] G4 = 7'b0110011;
    localparam logic [6:0] G5 = 7'b1011011;
    localparam logic [6:0] G7 = 7'b1110010;
    localparam logic [6:0] G9 = 7'b1111011;
    localparam logic [6:0] GB = 7'b0000000;
    localparam logic [6:0] GD = 7'b0000001;

    initial begin
        int nb;
        n_chk      = 0;
        n_bad      = 0;
        FPGA_RSTB  = 1'b0;
        value_in   = '0;
        value_load = 1'b0;
        blank_lz   = 1'b1;
        dp_mask    = 4'b0000;

        #22;
        check_val("rst_digit", 32'(DIGIT), 32'd0);
        check_val("rst_seg", 32'(SEG), 32'd0);
        check_val("rst_dp", 32'(SEG_DP), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_ovf", 32'(overflow), 32'd0);

        // Digit walk from reset release: slot k%8, index (k/8)%4, ghost at slot 0.
        @(negedge FPGA_CLK);
        FPGA_RSTB = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            logic [3:0] exp_d;
            if (k > 0) @(negedge FPGA_CLK);
            exp_d = (k % 8 == 0) ? 4'b0000 : 4'(4'b0001 << ((k / 8) % 4));
            check_val($sformatf("walk%0d", k), 32'(DIGIT), 32'(exp_d));
        end
        check_frame("zero_lz", GB, GB, GB, G0, 4'b0000);

        // 1234: busy exactly VAL_W+1 cycles.
        pulse_load(14'd1234);
        measure_busy(0, 14'd0, nb);
        check_val("busy_1234", 32'(nb), 32'd15);
        check_val("ovf_1234", 32'(overflow), 32'd0);
        check_frame("v1234", G1, G2, G3, G4, 4'b0000);

        // 7 with leading-zero blanking and a DP on digit 2, then unblanked.
        dp_mask = 4'b0100;
        pulse_load(14'd7);
        measure_busy(0, 14'd0, nb);
        check_val("busy_7", 32'(nb), 32'd15);
        check_frame("v7lz", GB, GB, GB, G7, 4'b0100);
        blank_lz = 1'b0;
        check_frame("v7", G0, G0, G0, G7, 4'b0100);

        // Overflow shows dashes; DP still live.
        dp_mask = 4'b0001;
        pulse_load(14'd10000);
        measure_busy(0, 14'd0, nb);
        check_val("ovf_10000", 32'(overflow), 32'd1);
        check_frame("v10000", GD, GD, GD, GD, 4'b0001);
        dp_mask = 4'b0000;
        pulse_load(14'd9999);
        measure_busy(0, 14'd0, nb);
        check_val("ovf_9999", 32'(overflow), 32'd0);
        check_frame("v9999", G9, G9, G9, G9, 4'b0000);

        // Reload during conversion: 100 superseded by 250.
        pulse_load(14'd100);
        measure_busy(5, 14'd250, nb);
        check_val("busy_pend", 32'(nb), 32'd30);
        check_frame("v250", G0, G2, G5, G0, 4'b0000);

        // Reset in mid-conversion with a pending value queued.
        dp_mask = 4'b1111;
        pulse_load(14'd12000);
        measure_busy(0, 14'd0, nb);
        check_val("ovf_12000", 32'(overflow), 32'd1);
        repeat (40) @(negedge FPGA_CLK);
        pulse_load(14'd300);
        @(negedge FPGA_CLK);
        value_in   = 14'd4321;
        value_load = 1'b1;
        @(negedge FPGA_CLK);
        value_load = 1'b0;
        repeat (3) @(negedge FPGA_CLK);
        check_val("pre_rst_busy", 32'(busy), 32'd1);
        FPGA_RSTB = 1'b0;
        #1;
        check_val("mrst_digit", 32'(DIGIT), 32'd0);
        check_val("mrst_seg", 32'(SEG), 32'd0);
        check_val("mrst_dp", 32'(SEG_DP), 32'd0);
        check_val("mrst_busy", 32'(busy), 32'd0);
        check_val("mrst_ovf", 32'(overflow), 32'd0);
        @(negedge FPGA_CLK);
        FPGA_RSTB = 1'b1;
        dp_mask   = 4'b0000;
        check_frame("post_rst", G0, G0, G0, G0, 4'b0000);
        check_val("post_rst_busy", 32'(busy), 32'd0);
        check_val("post_rst_ovf", 32'(overflow), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
